// File: rtl/scene_arbiter_pkg.sv
// Shared scene codes, FSM state encoding and full-brightness level for the scene arbiter.
package scene_arbiter_pkg;

    localparam int FADE_MAX = 16;

    localparam logic [1:0] SCENE_WELCOME = 2'd0;
    localparam logic [1:0] SCENE_TERM    = 2'd1;
    localparam logic [1:0] SCENE_GAME    = 2'd2;

    typedef enum logic [1:0] {
        ST_WELCOME,
        ST_SHOW,
        ST_FADE_OUT,
        ST_FADE_IN
    } state_t;

endpackage

// File: rtl/rgb_dimmer.sv
// Combinational per-channel brightness scaler: out = (c * level) >> 4.
module rgb_dimmer (
    input  logic [23:0] rgb,
    input  logic [4:0]  level,
    output logic [23:0] rgb_dim
);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [12:0] prod;
        assign prod = {5'd0, rgb[c*8 +: 8]} * {8'd0, level};
        assign rgb_dim[c*8 +: 8] = 8'(prod >> 4);
    end

endmodule

// File: rtl/scene_arbiter.sv
// Picks the display source (welcome/term/game) and cross-fades between scenes in
// frame-tick steps, scaling the selected pixel by the current brightness level.
module scene_arbiter
    import scene_arbiter_pkg::*;
#(
    parameter int FADE_STEP_FRAMES = 2,
    parameter int FADE_MAX         = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        in_welcome,
    input  logic        req_term,
    input  logic        req_game,
    input  logic [23:0] rgb_welcome,
    input  logic [23:0] rgb_term,
    input  logic [23:0] rgb_game,
    output logic [23:0] rgb_out,
    output logic [1:0]  scene,
    output logic        grant_term,
    output logic        grant_game,
    output logic        busy
);

    localparam logic [4:0] LVL_MAX   = 5'(FADE_MAX);
    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

    state_t      state;
    logic [4:0]  level;
    logic [1:0]  target;
    logic [7:0]  fcnt;
    logic [1:0]  desired;
    logic [23:0] src_rgb;
    logic [23:0] dim_rgb;
    logic        step;
    logic        unused_req_term;

    // Terminal is the fallback scene, so its request line carries no extra information.
    assign unused_req_term = req_term;
    assign desired = req_game ? SCENE_GAME : SCENE_TERM;
    assign step    = frame_tick && (fcnt == STEP_LAST);

    always_comb begin
        src_rgb = 24'h000000;
        case (scene)
            SCENE_WELCOME: src_rgb = rgb_welcome;
            SCENE_TERM:    src_rgb = rgb_term;
            SCENE_GAME:    src_rgb = rgb_game;
            default:       src_rgb = 24'h000000;
        endcase
    end

    rgb_dimmer u_dimmer (
        .rgb     (src_rgb),
        .level   (level),
        .rgb_dim (dim_rgb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WELCOME;
            scene      <= SCENE_WELCOME;
            level      <= LVL_MAX;
            target     <= SCENE_TERM;
            fcnt       <= 8'd0;
            rgb_out    <= 24'h000000;
            grant_term <= 1'b0;
            grant_game <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rgb_out <= dim_rgb;
            case (state)
                ST_WELCOME: begin
                    if (!in_welcome) begin
                        state <= ST_FADE_IN;
                        scene <= SCENE_TERM;
                        level <= 5'd0;
                        fcnt  <= 8'd0;
                        busy  <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (desired != scene) begin
                        target     <= desired;
                        state      <= ST_FADE_OUT;
                        fcnt       <= 8'd0;
                        busy       <= 1'b1;
                        grant_term <= 1'b0;
                        grant_game <= 1'b0;
                    end
                end
                ST_FADE_OUT: begin
                    if (step) begin
                        fcnt <= 8'd0;
                        // Scene swaps at black so the cut is invisible.
                        if (level <= 5'd1) begin
                            level <= 5'd0;
                            scene <= target;
                            state <= ST_FADE_IN;
                        end else begin
                            level <= level - 5'd1;
                        end
                    end else if (frame_tick) begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
                ST_FADE_IN: begin
                    if (step) begin
                        fcnt <= 8'd0;
                        if (level >= LVL_MAX - 5'd1) begin
                            level      <= LVL_MAX;
                            state      <= ST_SHOW;
                            busy       <= 1'b0;
                            grant_term <= (scene == SCENE_TERM);
                            grant_game <= (scene == SCENE_GAME);
                        end else begin
                            level <= level + 5'd1;
                        end
                    end else if (frame_tick) begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
                default: state <= ST_WELCOME;
            endcase
        end
    end

endmodule

// File: tb/tb_scene_arbiter.sv
// Directed bench for scene_arbiter: welcome hand-off, cross-fades, scaling and reset.
module tb_scene_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        in_welcome;
    logic        req_term;
    logic        req_game;
    logic [23:0] rgb_welcome;
    logic [23:0] rgb_term;
    logic [23:0] rgb_game;
    logic [23:0] rgb_out;
    logic [1:0]  scene;
    logic        grant_term;
    logic        grant_game;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;

    scene_arbiter #(.FADE_STEP_FRAMES(2), .FADE_MAX(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .in_welcome  (in_welcome),
        .req_term    (req_term),
        .req_game    (req_game),
        .rgb_welcome (rgb_welcome),
        .rgb_term    (rgb_term),
        .rgb_game    (rgb_game),
        .rgb_out     (rgb_out),
        .scene       (scene),
        .grant_term  (grant_term),
        .grant_game  (grant_game),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One frame tick pulse, then one idle cycle so rgb_out reflects the new level.
    task automatic tick_frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 1'b0; in_welcome = 1'b1;
        req_term = 1'b0; req_game = 1'b0;
        rgb_welcome = 24'hD2C4C1; rgb_term = 24'hFFFFFF; rgb_game = 24'h00FF00;
        repeat (3) @(negedge clk);
        ntests++;
        if (rgb_out !== 24'h0 || scene !== 2'd0 || busy !== 1'b0 || grant_term !== 1'b0 || grant_game !== 1'b0) begin
            nfail++;
            $display("FAIL reset_state: rgb=%h scene=%0d busy=%b gt=%b gg=%b, want 000000 0 0 0 0",
                     rgb_out, scene, busy, grant_term, grant_game);
        end
        rst_n = 1'b1;
        @(negedge clk);
        ntests++;
        if (rgb_out !== 24'hD2C4C1 || scene !== 2'd0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL welcome_pass: rgb=%h scene=%0d busy=%b, want D2C4C1 0 0", rgb_out, scene, busy);
        end
    endtask

    task automatic test_welcome_fade_in();
        logic [7:0] ch;
        in_welcome = 1'b0;
        @(negedge clk);
        ntests++;
        if (scene !== 2'd1 || busy !== 1'b1 || grant_term !== 1'b0) begin
            nfail++;
            $display("FAIL welcome_exit: scene=%0d busy=%b gt=%b, want 1 1 0", scene, busy, grant_term);
        end
        @(negedge clk);
        ntests++;
        if (rgb_out !== 24'h000000) begin
            nfail++;
            $display("FAIL fade_in_black: got %h want 000000", rgb_out);
        end
        for (int k = 1; k <= 32; k++) begin
            tick_frame();
            ch = 8'((255 * (k / 2)) >> 4);
            ntests++;
            if (rgb_out !== {ch, ch, ch}) begin
                nfail++;
                $display("FAIL fade_in_level k=%0d: got %h want %h", k, rgb_out, {ch, ch, ch});
            end
            if (k == 16) begin
                rgb_term = 24'hFF8001;
                @(negedge clk);
                ntests++;
                if (rgb_out !== 24'h7F4000) begin
                    nfail++;
                    $display("FAIL scale_half: got %h want 7F4000", rgb_out);
                end
                rgb_term = 24'hFFFFFF;
            end
            if (k == 31) begin
                ntests++;
                if (busy !== 1'b1 || grant_term !== 1'b0) begin
                    nfail++;
                    $display("FAIL fade_in_busy: busy=%b gt=%b, want 1 0", busy, grant_term);
                end
            end
        end
        ntests++;
        if (scene !== 2'd1 || busy !== 1'b0 || grant_term !== 1'b1 || grant_game !== 1'b0) begin
            nfail++;
            $display("FAIL term_granted: scene=%0d busy=%b gt=%b gg=%b, want 1 0 1 0",
                     scene, busy, grant_term, grant_game);
        end
    endtask

    task automatic test_switch_to_game();
        req_game = 1'b1;
        @(negedge clk);
        ntests++;
        if (busy !== 1'b1 || grant_term !== 1'b0 || scene !== 2'd1) begin
            nfail++;
            $display("FAIL fade_out_start: busy=%b gt=%b scene=%0d, want 1 0 1", busy, grant_term, scene);
        end
        ticks(31);
        ntests++;
        if (scene !== 2'd1 || rgb_out !== 24'h0F0F0F) begin
            nfail++;
            $display("FAIL fade_out_level1: scene=%0d rgb=%h, want 1 0F0F0F", scene, rgb_out);
        end
        tick_frame();
        ntests++;
        if (scene !== 2'd2 || busy !== 1'b1 || rgb_out !== 24'h000000) begin
            nfail++;
            $display("FAIL swap_at_black: scene=%0d busy=%b rgb=%h, want 2 1 000000", scene, busy, rgb_out);
        end
        ticks(32);
        ntests++;
        if (grant_game !== 1'b1 || grant_term !== 1'b0 || busy !== 1'b0 || rgb_out !== 24'h00FF00) begin
            nfail++;
            $display("FAIL game_granted: gg=%b gt=%b busy=%b rgb=%h, want 1 0 0 00FF00",
                     grant_game, grant_term, busy, rgb_out);
        end
        in_welcome = 1'b1;
        repeat (3) @(negedge clk);
        ntests++;
        if (scene !== 2'd2 || grant_game !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL welcome_ignored: scene=%0d gg=%b busy=%b, want 2 1 0", scene, grant_game, busy);
        end
        in_welcome = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_game = 1'b0;
        @(negedge clk);
        ticks(64);
        ntests++;
        if (scene !== 2'd1 || grant_term !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL back_to_term: scene=%0d gt=%b busy=%b, want 1 1 0", scene, grant_term, busy);
        end
        req_game = 1'b1;
        @(negedge clk);
        ticks(10);
        req_game = 1'b0;
        ticks(22);
        ntests++;
        if (scene !== 2'd2 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL drop_ignored: scene=%0d busy=%b, want 2 1", scene, busy);
        end
        ticks(31);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ntests++;
        if (scene !== 2'd2 || grant_game !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL drop_lands_game: scene=%0d gg=%b busy=%b, want 2 1 0", scene, grant_game, busy);
        end
        @(negedge clk);
        ntests++;
        if (scene !== 2'd2 || grant_game !== 1'b0 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL drop_refade: scene=%0d gg=%b busy=%b, want 2 0 1", scene, grant_game, busy);
        end
    endtask

    task automatic test_reset_mid_fade();
        ticks(32);
        ticks(10);
        ntests++;
        if (scene !== 2'd1 || busy !== 1'b1 || rgb_out !== 24'h4F4F4F) begin
            nfail++;
            $display("FAIL fade_in_level5: scene=%0d busy=%b rgb=%h, want 1 1 4F4F4F", scene, busy, rgb_out);
        end
        rst_n = 1'b0;
        #1;
        ntests++;
        if (scene !== 2'd0 || rgb_out !== 24'h0 || busy !== 1'b0 || grant_term !== 1'b0 || grant_game !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid_fade: scene=%0d rgb=%h busy=%b gt=%b gg=%b, want 0 000000 0 0 0",
                     scene, rgb_out, busy, grant_term, grant_game);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ntests++;
        if (scene !== 2'd1 || busy !== 1'b1 || rgb_out !== 24'hD2C4C1) begin
            nfail++;
            $display("FAIL post_reset_exit: scene=%0d busy=%b rgb=%h, want 1 1 D2C4C1", scene, busy, rgb_out);
        end
    endtask

    initial begin
        test_reset();
        test_welcome_fade_in();
        test_switch_to_game();
        test_back_to_back();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/scene_arbiter.md
SCENE_ARBITER -- requirements
Module: scene_arbiter

Interface
REQ-001 Parameter FADE_STEP_FRAMES, default 2, frames per brightness step (legal 1..255).
REQ-002 Parameter FADE_MAX, default 16, full-brightness level; fixed at 16.
REQ-003 clk  input  1  pixel/system clock, shared with the VGA controller.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 frame_tick  input  1  one-cycle pulse per VGA frame (start of vertical blank).
REQ-006 in_welcome  input  1  high while the welcome screen owns the display.
REQ-007 req_term  input  1  level request for the text terminal scene.
REQ-008 req_game  input  1  level request for the graphics/game scene.
REQ-009 rgb_welcome  input  24  welcome scene pixel.
REQ-010 rgb_term  input  24  terminal scene pixel.
REQ-011 rgb_game  input  24  game scene pixel.
REQ-012 rgb_out  output  24  arbitrated, brightness-scaled pixel to the VGA controller.
REQ-013 scene  output  2  current source: 0 welcome, 1 term, 2 game; 3 unused.
REQ-014 grant_term  output  1  terminal owns keyboard/display (scene==1, not fading).
REQ-015 grant_game  output  1  game owns keyboard/display (scene==2, not fading).
REQ-016 busy  output  1  high during FADE_OUT or FADE_IN.

Function
REQ-017 States: WELCOME, SHOW, FADE_OUT, FADE_IN.
REQ-018 WELCOME: scene=0, level=16; on in_welcome low -> level forced to 0, scene=1, FADE_IN.
REQ-019 Desired scene in SHOW = 2 if req_game else 1 (game has priority).
REQ-020 SHOW: if desired != scene, latch target=desired, go FADE_OUT; else hold.
REQ-021 FADE_OUT: level decrements by 1 each FADE_STEP_FRAMES frame_ticks; when level reaches 0 -> scene=target, FADE_IN on the same cycle.
REQ-022 FADE_IN: level increments by 1 each FADE_STEP_FRAMES frame_ticks; at level 16 -> SHOW.
REQ-023 Frame counter counts frame_ticks only in fade states; clears on every state change.
REQ-024 Request changes during FADE_OUT/FADE_IN are ignored; desired is re-evaluated on the first SHOW cycle.
REQ-025 in_welcome is sampled only in WELCOME; reasserting it later has no effect.
REQ-026 Source pixel per scene: 0 rgb_welcome, 1 rgb_term, 2 rgb_game, 3 24'h000000.
REQ-027 Each 8-bit channel out = (c * level) >> 4, 13-bit intermediate; level 16 passes c unchanged, level 0 gives 0.
REQ-028 rgb_out registered: exactly 1 clk latency from rgb_* inputs; scene/level used are those of the same cycle.
REQ-029 level never below 0 or above 16; no wrap-around.
REQ-030 frame_tick coincident with a state transition is consumed by the new state's counter only if in a fade state.
REQ-031 grant_* and busy are registered, derived from next-state values, no glitches.

Reset
REQ-032 On rst_n low: state=WELCOME, scene=0, level=16, target=1, frame counter=0, rgb_out=0, grant_term=0, grant_game=0, busy=0.
REQ-033 Reset mid-fade abandons the fade immediately; first post-reset cycle behaves as REQ-018.

Structure
REQ-034 Shared package holds scene codes (SCENE_WELCOME/TERM/GAME), state encoding, FADE_MAX.
REQ-035 One sub-module rgb_dimmer: combinational 24-bit x 5-bit level scaler per REQ-027, instantiated once.

Verification
REQ-036 Reset, in_welcome=1, rgb_welcome=24'hD2C4C1 -> rgb_out=24'hD2C4C1 one clk later, scene=0, busy=0.
REQ-037 in_welcome 1->0, FADE_STEP_FRAMES=2 -> scene=1, level 0..16 over 32 frame_ticks, then grant_term=1, busy=0.
REQ-038 In SHOW term, req_game=1 -> 32 ticks FADE_OUT, scene switches to 2 at level 0, 32 ticks FADE_IN, grant_game=1.
REQ-039 req_game dropped mid-FADE_OUT -> fade completes to game, then immediately starts FADE_OUT back to term.
REQ-040 level=8, rgb_term=24'hFF8001 -> rgb_out=24'h7F4000.
REQ-041 rst_n low mid-FADE_IN at level 5 -> next cycle scene=0, rgb_out=0, busy=0, grant_*=0.
